pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage ARM pipeline.
- Drives the freeze/flush inputs of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Inputs: ID-stage source registers, EX/MEM destination info, the EX-stage taken-branch flag and the SRAM ready handshake.
- Contains the branch-flush sequencer, the memory-wait FSM with timeout watchdog, and the RAW-hazard stall logic.

Parameters:
- FLUSH_CYCLES, 1: cycles IF/ID and ID/EX are flushed after a taken branch (1..15).
- MEM_TIMEOUT, 255: consecutive memory-wait cycles before mem_timeout is raised (1..65535).

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-low reset (asserted at 0).
- src_1  in  4  Rn of the instruction in ID.
- src_2  in  4  Rm/Rd of the instruction in ID.
- use_src_1  in  1  ID instruction reads src_1.
- two_src  in  1  ID instruction reads src_2.
- ex_dest  in  4  dest of the instruction in EX.
- ex_wb_en  in  1  EX instruction writes back.
- mem_dest  in  4  dest of the instruction in MEM.
- mem_wb_en  in  1  MEM instruction writes back.
- branch_taken  in  1  EX-stage taken branch (ID/EX b_out).
- mem_req  in  1  MEM stage has MEM_r_en or MEM_w_en active.
- mem_ready  in  1  SRAM completes the access this cycle.
- freeze_pc  out  1  hold PC.
- freeze_if_id  out  1  hold IF/ID.
- flush_if_id  out  1  clear IF/ID.
- freeze_id_ex  out  1  hold ID/EX.
- flush_id_ex  out  1  clear ID/EX (bubble).
- freeze_ex_mem  out  1  hold EX/MEM.
- freeze_mem_wb  out  1  hold MEM/WB.
- mem_timeout  out  1  sticky watchdog error.

Behaviour:
- FSM states: RUN, MEM_WAIT, FLUSH.
- Registers: 4-bit flush counter fcnt; wait counter wcnt of width clog2(MEM_TIMEOUT+1).
- Reset (rst=0, async):
  - State RUN; fcnt=0, wcnt=0, mem_timeout=0.
  - All freeze/flush outputs are combinational and evaluate to 0 while in reset.
- Hazard term haz:
  - (use_src_1 & ex_wb_en & ex_dest==src_1)
  - | (two_src & ex_wb_en & ex_dest==src_2)
  - | the same two terms using mem_dest/mem_wb_en.
- mem_stall = mem_req & ~mem_ready.
- Output priority within a cycle: mem_stall > branch/FLUSH > haz.
  - mem_stall (any state): freeze_pc, freeze_if_id, freeze_id_ex, freeze_ex_mem, freeze_mem_wb = 1; all flushes = 0.
  - Else branch_taken in RUN, or state FLUSH: flush_if_id = flush_id_ex = 1; freeze_pc = 0 so the branch target loads.
  - Else haz: freeze_pc = freeze_if_id = 1, flush_id_ex = 1; EX/MEM and MEM/WB advance.
  - Else: all outputs 0.
- Transitions:
  - RUN → MEM_WAIT on mem_stall; wcnt=1.
  - RUN → FLUSH on branch_taken & ~mem_stall when FLUSH_CYCLES>1; fcnt=FLUSH_CYCLES-1. When FLUSH_CYCLES=1, stay in RUN.
  - MEM_WAIT:
    - wcnt increments each stalled cycle and saturates at MEM_TIMEOUT.
    - When wcnt==MEM_TIMEOUT and mem_stall: mem_timeout <= 1, sticky until reset. The pipeline stays frozen; there is no recovery.
    - On mem_ready: go to RUN, wcnt=0. The cycle mem_ready is seen is unfrozen.
  - FLUSH: fcnt decrements each cycle; at fcnt==1 → RUN.
  - mem_stall arriving while in FLUSH: outputs obey the priority above; fcnt holds; state stays FLUSH; MEM_WAIT is not entered.
- Branch under memory stall: EX is frozen, so branch_taken stays asserted and is acted on the first unstalled cycle.
- A new branch_taken while in FLUSH is ignored; it cannot occur, because ID/EX is being flushed.
- Latency: all hazard/flush responses are same-cycle combinational; only the state, counters and mem_timeout are registered.
- Reset mid-operation: immediate return to RUN with counters cleared.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined:
  - Adds input perf_clr (1) and outputs haz_cycles, mem_cycles, flush_cycles (16 each).
  - Each counter increments on every cycle its output branch is active (haz, mem_stall, or flush respectively) and saturates at 16'hFFFF.
  - perf_clr synchronously zeroes all three counters and takes priority over increment.
  - Reset clears all three.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Reset: rst=0 mid-MEM_WAIT with mem_timeout=1 → all outputs 0, mem_timeout 0; after release, state RUN.
- RAW: src_1=3, use_src_1=1, ex_dest=3, ex_wb_en=1 → freeze_pc=freeze_if_id=flush_id_ex=1 that cycle; ex_wb_en=0 next cycle → all 0.
- Branch, FLUSH_CYCLES=2: branch_taken=1 for one cycle → flush_if_id=flush_id_ex=1 for exactly 2 cycles, freeze_pc=0 throughout.
- Memory: mem_req=1, mem_ready=0 for 5 cycles, then 1 → five freeze-all cycles, no freeze on the sixth.
- Priority: mem_stall, branch_taken and haz all asserted → only the freezes assert. After mem_ready=1 → flush pulse, not a hazard stall.
- Watchdog, MEM_TIMEOUT=4: mem_req=1, mem_ready=0 held → mem_timeout rises after the 4th stall cycle and stays 1 after mem_ready=1.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// ============================================================================
//  Module      : pipe_hazard_ctrl_if
//  Description : Hazard-control bundle between the 5-stage pipeline and the
//                stall/flush sequencer. The pipeline side uses the master
//                modport and the sequencer uses the slave modport.
//                HAZARD_PERF_CNT_EN adds the performance-counter signals.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pipe_hazard_ctrl_if;
  // ID-stage operands
  logic [3:0]  src_1;
  logic [3:0]  src_2;
  logic        use_src_1;
  logic        two_src;
  // Destinations further down the pipe
  logic [3:0]  ex_dest;
  logic        ex_wb_en;
  logic [3:0]  mem_dest;
  logic        mem_wb_en;
  // Control-flow and memory handshake
  logic        branch_taken;
  logic        mem_req;
  logic        mem_ready;
  // Register controls
  logic        freeze_pc;
  logic        freeze_if_id;
  logic        flush_if_id;
  logic        freeze_id_ex;
  logic        flush_id_ex;
  logic        freeze_ex_mem;
  logic        freeze_mem_wb;
  logic        mem_timeout;
`ifdef HAZARD_PERF_CNT_EN
  logic        perf_clr;
  logic [15:0] haz_cycles;
  logic [15:0] mem_cycles;
  logic [15:0] flush_cycles;
`endif

  modport master (
    output src_1, src_2, use_src_1, two_src, ex_dest, ex_wb_en,
           mem_dest, mem_wb_en, branch_taken, mem_req, mem_ready,
`ifdef HAZARD_PERF_CNT_EN
    output perf_clr,
    input  haz_cycles, mem_cycles, flush_cycles,
`endif
    input  freeze_pc, freeze_if_id, flush_if_id, freeze_id_ex,
           flush_id_ex, freeze_ex_mem, freeze_mem_wb, mem_timeout
  );

  modport slave (
    input  src_1, src_2, use_src_1, two_src, ex_dest, ex_wb_en,
           mem_dest, mem_wb_en, branch_taken, mem_req, mem_ready,
`ifdef HAZARD_PERF_CNT_EN
    input  perf_clr,
    output haz_cycles, mem_cycles, flush_cycles,
`endif
    output freeze_pc, freeze_if_id, flush_if_id, freeze_id_ex,
           flush_id_ex, freeze_ex_mem, freeze_mem_wb, mem_timeout
  );
endinterface

`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
// ============================================================================
//  Module      : pipe_hazard_ctrl
//  Description : Central stall/flush sequencer for the 5-stage pipeline.
//                Combines RAW-hazard stalls, a post-branch flush sequencer
//                and a memory-wait FSM with a sticky timeout watchdog.
//                Optional macro HAZARD_PERF_CNT_EN adds saturating
//                hazard/memory/flush cycle counters.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 1,   // 1..15
  parameter int MEM_TIMEOUT  = 255  // 1..65535
) (
  input  logic             clk,
  input  logic             rst,     // asynchronous, active low
  pipe_hazard_ctrl_if.slave hz
);

  localparam int                  c_WCNT_W     = $clog2(MEM_TIMEOUT + 1);
  localparam logic [c_WCNT_W-1:0] c_WCNT_MAX   = c_WCNT_W'(MEM_TIMEOUT);
  localparam logic [c_WCNT_W-1:0] c_WCNT_ONE   = c_WCNT_W'(1);
  localparam logic [3:0]          c_FLUSH_INIT = 4'(FLUSH_CYCLES - 1);
  localparam bit                  c_FLUSH_MULTI = (FLUSH_CYCLES > 1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_FLUSH    = 2'd2
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [3:0]          r_fcnt, w_fcnt_nxt;
  logic [c_WCNT_W-1:0] r_wcnt, w_wcnt_nxt;
  logic                r_mem_timeout, w_timeout_set;

  logic w_haz, w_mem_stall, w_flush_req;
  logic w_freeze_all, w_flush_act, w_haz_act;

  assign w_haz = (hz.use_src_1 & hz.ex_wb_en  & (hz.ex_dest  == hz.src_1))
               | (hz.two_src   & hz.ex_wb_en  & (hz.ex_dest  == hz.src_2))
               | (hz.use_src_1 & hz.mem_wb_en & (hz.mem_dest == hz.src_1))
               | (hz.two_src   & hz.mem_wb_en & (hz.mem_dest == hz.src_2));

  assign w_mem_stall = hz.mem_req & ~hz.mem_ready;

  // A branch held in EX across a memory stall is honoured on the first
  // unstalled cycle, which may be the MEM_WAIT cycle that sees mem_ready.
  // In FLUSH a new branch_taken cannot occur, so OR-ing it in is harmless.
  assign w_flush_req = hz.branch_taken | (r_state == ST_FLUSH);

  // Priority resolution: memory stall, then flush, then RAW hazard
  always_comb begin
    w_freeze_all = 1'b0;
    w_flush_act  = 1'b0;
    w_haz_act    = 1'b0;
    if (w_mem_stall)      w_freeze_all = 1'b1;
    else if (w_flush_req) w_flush_act  = 1'b1;
    else if (w_haz)       w_haz_act    = 1'b1;
  end

  // Register controls are forced low while reset is asserted
  assign hz.freeze_pc     = rst & (w_freeze_all | w_haz_act);
  assign hz.freeze_if_id  = rst & (w_freeze_all | w_haz_act);
  assign hz.flush_if_id   = rst & w_flush_act;
  assign hz.freeze_id_ex  = rst & w_freeze_all;
  assign hz.flush_id_ex   = rst & (w_flush_act | w_haz_act);
  assign hz.freeze_ex_mem = rst & w_freeze_all;
  assign hz.freeze_mem_wb = rst & w_freeze_all;
  assign hz.mem_timeout   = r_mem_timeout;

  // Next-state, counter and watchdog logic
  always_comb begin
    w_state_nxt   = r_state;
    w_fcnt_nxt    = r_fcnt;
    w_wcnt_nxt    = r_wcnt;
    w_timeout_set = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (w_mem_stall) begin
          w_state_nxt = ST_MEM_WAIT;
          w_wcnt_nxt  = c_WCNT_ONE;
        end else if (hz.branch_taken && c_FLUSH_MULTI) begin
          w_state_nxt = ST_FLUSH;
          w_fcnt_nxt  = c_FLUSH_INIT;
        end
      end
      ST_MEM_WAIT: begin
        if (w_mem_stall) begin
          // Counter saturates; the error is latched once the limit is seen
          if (r_wcnt == c_WCNT_MAX) w_timeout_set = 1'b1;
          else                      w_wcnt_nxt    = r_wcnt + c_WCNT_ONE;
        end else begin
          w_wcnt_nxt = '0;
          if (hz.branch_taken && c_FLUSH_MULTI) begin
            w_state_nxt = ST_FLUSH;
            w_fcnt_nxt  = c_FLUSH_INIT;
          end else begin
            w_state_nxt = ST_RUN;
          end
        end
      end
      ST_FLUSH: begin
        // A memory stall during the flush simply holds the count
        if (!w_mem_stall) begin
          if (r_fcnt <= 4'd1) begin
            w_state_nxt = ST_RUN;
            w_fcnt_nxt  = 4'd0;
          end else begin
            w_fcnt_nxt  = r_fcnt - 4'd1;
          end
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
        w_fcnt_nxt  = 4'd0;
        w_wcnt_nxt  = '0;
      end
    endcase
  end

  // State, counters and sticky watchdog flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= ST_RUN;
      r_fcnt        <= 4'd0;
      r_wcnt        <= '0;
      r_mem_timeout <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_fcnt  <= w_fcnt_nxt;
      r_wcnt  <= w_wcnt_nxt;
      if (w_timeout_set) r_mem_timeout <= 1'b1;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] r_haz_cycles, r_mem_cycles, r_flush_cycles;

  // Saturating activity counters; clear wins over increment
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_haz_cycles   <= 16'd0;
      r_mem_cycles   <= 16'd0;
      r_flush_cycles <= 16'd0;
    end else if (hz.perf_clr) begin
      r_haz_cycles   <= 16'd0;
      r_mem_cycles   <= 16'd0;
      r_flush_cycles <= 16'd0;
    end else begin
      if (w_haz_act && (r_haz_cycles != 16'hFFFF))
        r_haz_cycles <= r_haz_cycles + 16'd1;
      if (w_freeze_all && (r_mem_cycles != 16'hFFFF))
        r_mem_cycles <= r_mem_cycles + 16'd1;
      if (w_flush_act && (r_flush_cycles != 16'hFFFF))
        r_flush_cycles <= r_flush_cycles + 16'd1;
    end
  end

  assign hz.haz_cycles   = r_haz_cycles;
  assign hz.mem_cycles   = r_mem_cycles;
  assign hz.flush_cycles = r_flush_cycles;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
// ============================================================================
//  Module      : tb_pipe_hazard_ctrl
//  Description : Directed, table-driven bench for pipe_hazard_ctrl with
//                FLUSH_CYCLES=2 and MEM_TIMEOUT=4.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_hazard_ctrl;

  // Output vector order:
  // {mem_timeout, freeze_pc, freeze_if_id, flush_if_id, freeze_id_ex,
  //  flush_id_ex, freeze_ex_mem, freeze_mem_wb}
  localparam logic [7:0] c_NONE  = 8'b0_0000000;
  localparam logic [7:0] c_FRZ   = 8'b0_1101011;
  localparam logic [7:0] c_FLUSH = 8'b0_0010100;
  localparam logic [7:0] c_HAZ   = 8'b0_1100100;

  typedef struct {
    logic [3:0] src_1;
    logic [3:0] src_2;
    logic       use_src_1;
    logic       two_src;
    logic [3:0] ex_dest;
    logic       ex_wb_en;
    logic [3:0] mem_dest;
    logic       mem_wb_en;
    logic       branch_taken;
    logic       mem_req;
    logic       mem_ready;
    logic [7:0] exp;
  } vec_t;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  pipe_hazard_ctrl_if hz();

  pipe_hazard_ctrl #(
    .FLUSH_CYCLES (2),
    .MEM_TIMEOUT  (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] outs();
    return {hz.mem_timeout, hz.freeze_pc, hz.freeze_if_id, hz.flush_if_id,
            hz.freeze_id_ex, hz.flush_id_ex, hz.freeze_ex_mem, hz.freeze_mem_wb};
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  task automatic apply(input vec_t v);
    hz.src_1        = v.src_1;
    hz.src_2        = v.src_2;
    hz.use_src_1    = v.use_src_1;
    hz.two_src      = v.two_src;
    hz.ex_dest      = v.ex_dest;
    hz.ex_wb_en     = v.ex_wb_en;
    hz.mem_dest     = v.mem_dest;
    hz.mem_wb_en    = v.mem_wb_en;
    hz.branch_taken = v.branch_taken;
    hz.mem_req      = v.mem_req;
    hz.mem_ready    = v.mem_ready;
  endtask

  function automatic vec_t idle();
    vec_t v;
    v = '{4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, c_NONE};
    return v;
  endfunction

  // Sample at the falling edge, then move to just after the next rising edge
  task automatic cycle_check(input string name, input logic [7:0] exp);
    @(negedge clk);
    check(name, outs(), exp);
    @(posedge clk);
    #1;
  endtask

  task automatic cycle_check_outs(input string name, input logic [6:0] exp);
    @(negedge clk);
    check(name, {1'b0, outs()}, {1'b0, exp[6:0]});
    @(posedge clk);
    #1;
  endtask

  vec_t tbl [14];
  vec_t v;

  initial begin
    n_pass  = 0;
    n_total = 0;
`ifdef HAZARD_PERF_CNT_EN
    hz.perf_clr = 1'b0;
`endif
    //         src1  src2  u1 two exd  exw  memd mw  br  req rdy  expected
    tbl[0]  = '{4'd0, 4'd0, 0, 0, 4'd0, 0, 4'd0, 0, 0, 0, 0, c_NONE};
    tbl[1]  = '{4'd3, 4'd0, 1, 0, 4'd3, 1, 4'd0, 0, 0, 0, 0, c_HAZ};
    tbl[2]  = '{4'd3, 4'd0, 1, 0, 4'd3, 0, 4'd0, 0, 0, 0, 0, c_NONE};
    tbl[3]  = '{4'd0, 4'd5, 0, 1, 4'd0, 0, 4'd5, 1, 0, 0, 0, c_HAZ};
    tbl[4]  = '{4'd0, 4'd5, 0, 0, 4'd0, 0, 4'd5, 1, 0, 0, 0, c_NONE};
    tbl[5]  = '{4'd7, 4'd0, 1, 0, 4'd8, 1, 4'd0, 0, 0, 0, 0, c_NONE};
    tbl[6]  = '{4'd2, 4'd0, 1, 0, 4'd0, 0, 4'd2, 1, 0, 0, 0, c_HAZ};
    tbl[7]  = '{4'd0, 4'd15, 0, 1, 4'd15, 1, 4'd0, 0, 0, 0, 0, c_HAZ};
    tbl[8]  = '{4'd0, 4'd0, 0, 0, 4'd0, 0, 4'd0, 0, 1, 0, 0, c_FLUSH};
    tbl[9]  = '{4'd3, 4'd0, 1, 0, 4'd3, 1, 4'd0, 0, 1, 0, 0, c_FLUSH};
    tbl[10] = '{4'd0, 4'd0, 0, 0, 4'd0, 0, 4'd0, 0, 0, 1, 0, c_FRZ};
    tbl[11] = '{4'd0, 4'd0, 0, 0, 4'd0, 0, 4'd0, 0, 0, 1, 1, c_NONE};
    tbl[12] = '{4'd3, 4'd0, 1, 0, 4'd3, 1, 4'd0, 0, 1, 1, 0, c_FRZ};
    tbl[13] = '{4'd9, 4'd0, 1, 0, 4'd9, 1, 4'd0, 0, 0, 0, 0, c_HAZ};

    // Reset: outputs stay low even with a stall presented
    rst = 1'b0;
    v = idle(); v.mem_req = 1'b1;
    apply(v);
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", outs(), c_NONE);
    apply(idle());
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Single-cycle vectors from RUN, each followed by idle cycles to settle
    for (int i = 0; i < 14; i++) begin
      apply(tbl[i]);
      cycle_check($sformatf("vec%0d", i), tbl[i].exp);
      apply(idle());
      repeat (2) @(posedge clk);
      #1;
    end

    // RAW hazard then producer stops writing back
    v = idle(); v.src_1 = 4'd3; v.use_src_1 = 1'b1; v.ex_dest = 4'd3; v.ex_wb_en = 1'b1;
    apply(v);
    cycle_check("raw_stall", c_HAZ);
    v.ex_wb_en = 1'b0;
    apply(v);
    cycle_check("raw_clear", c_NONE);

    // One-cycle branch gives exactly two flush cycles
    v = idle(); v.branch_taken = 1'b1;
    apply(v);
    cycle_check("br_flush1", c_FLUSH);
    apply(idle());
    cycle_check("br_flush2", c_FLUSH);
    cycle_check("br_done", c_NONE);

    // Stall + branch + hazard: freezes only, then flush, then hazard
    v = idle(); v.mem_req = 1'b1; v.branch_taken = 1'b1;
    v.src_1 = 4'd3; v.use_src_1 = 1'b1; v.ex_dest = 4'd3; v.ex_wb_en = 1'b1;
    apply(v);
    cycle_check("prio_frz1", c_FRZ);
    cycle_check("prio_frz2", c_FRZ);
    v.mem_ready = 1'b1;
    apply(v);
    cycle_check("prio_flush1", c_FLUSH);
    v.mem_req = 1'b0; v.mem_ready = 1'b0; v.branch_taken = 1'b0;
    apply(v);
    cycle_check("prio_flush2", c_FLUSH);
    cycle_check("prio_haz", c_HAZ);
    apply(idle());
    cycle_check("prio_idle", c_NONE);

    // Memory stall arriving mid-flush holds the flush count
    v = idle(); v.branch_taken = 1'b1;
    apply(v);
    cycle_check("fl_stall_br", c_FLUSH);
    v = idle(); v.mem_req = 1'b1;
    apply(v);
    cycle_check("fl_stall_frz1", c_FRZ);
    cycle_check("fl_stall_frz2", c_FRZ);
    v.mem_ready = 1'b1;
    apply(v);
    cycle_check("fl_stall_flush", c_FLUSH);
    apply(idle());
    cycle_check("fl_stall_done", c_NONE);

    // Five stalled cycles, ready on the sixth; watchdog limit is 4
    v = idle(); v.mem_req = 1'b1;
    apply(v);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check($sformatf("mem_frz%0d", k), {1'b0, outs()}, {1'b0, c_FRZ[6:0]});
      if (k == 4) check("wdog_low", {7'd0, hz.mem_timeout}, 8'd0);
      @(posedge clk);
      #1;
    end
    v.mem_ready = 1'b1;
    apply(v);
    cycle_check("mem_release", 8'b1_0000000);
    apply(idle());
    cycle_check("wdog_sticky", 8'b1_0000000);

    // Asynchronous reset in the middle of a memory wait
    v = idle(); v.mem_req = 1'b1;
    apply(v);
    cycle_check("pre_rst_frz", 8'b1_1101011);
    rst = 1'b0;
    #1;
    check("rst_mid_wait", outs(), c_NONE);
    apply(idle());
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // After reset the FSM is in RUN with cleared counters
    v = idle(); v.branch_taken = 1'b1;
    apply(v);
    cycle_check("post_rst_flush1", c_FLUSH);
    apply(idle());
    cycle_check("post_rst_flush2", c_FLUSH);
    cycle_check("post_rst_idle", c_NONE);
    v = idle(); v.mem_req = 1'b1;
    apply(v);
    cycle_check("post_rst_frz", c_FRZ);
    v.mem_ready = 1'b1;
    apply(v);
    cycle_check("post_rst_rel", c_NONE);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
